// File: rtl/branch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : branch_pc_unit                                                |
// | Brief    : Next-PC select, B-type condition decode, PC register and the  |
// |            IDLE/FETCH/EXEC instruction-fetch sequencer.                  |
// |            Optional feature macro: INSTR_MISALIGN_TRAP_EN                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module branch_pc_unit #(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DWIDTH-1:0] TRAP_VECTOR  = DWIDTH'(32'h0000_0100)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Branch_Equal,
  input  logic              Branch_Lt,
  output logic              Branch_Un_Ctrl,
  input  logic [2:0]        Funct3,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Jalr,
  input  logic [DWIDTH-1:0] Imm,
  input  logic [DWIDTH-1:0] Read_Reg_Data_1,
  input  logic              Instr_Retire,
  input  logic              Fetch_Ready,
  output logic              Fetch_Valid,
  output logic [DWIDTH-1:0] Fetch_Addr,
  output logic [DWIDTH-1:0] PC,
  output logic [DWIDTH-1:0] PC_Plus_4,
  output logic              Branch_Taken,
  output logic              Trap_Misalign
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_EXEC  = 2'd2;

  logic [1:0]        r_state;
  logic [DWIDTH-1:0] r_pc;
  logic              r_trap;
  logic              w_cond;
  logic [DWIDTH-1:0] w_jalr_sum;
  logic [DWIDTH-1:0] w_next_pc;

  // Unsigned compare for BLTU/BGEU is selected by funct3 bit 1.
  assign Branch_Un_Ctrl = Funct3[1];

  always_comb begin
    w_cond = 1'b0;
    case (Funct3)
      3'b000:          w_cond = Branch_Equal;
      3'b001:          w_cond = ~Branch_Equal;
      3'b100, 3'b110:  w_cond = Branch_Lt;
      3'b101, 3'b111:  w_cond = ~Branch_Lt;
      default:         w_cond = 1'b0;
    endcase
  end

  assign Branch_Taken = Jump | (Branch & w_cond);
  assign w_jalr_sum   = Read_Reg_Data_1 + Imm;

  always_comb begin
    w_next_pc = r_pc + DWIDTH'(4);
    if (Jump && Jalr)
      w_next_pc = {w_jalr_sum[DWIDTH-1:1], 1'b0};
    else if (Branch_Taken)
      w_next_pc = r_pc + Imm;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= c_IDLE;
      r_pc    <= RESET_VECTOR;
      r_trap  <= 1'b0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        c_IDLE:  r_state <= c_FETCH;
        c_FETCH: if (Fetch_Ready) r_state <= c_EXEC;
        c_EXEC: begin
          if (Instr_Retire) begin
            r_state <= c_FETCH;
`ifdef INSTR_MISALIGN_TRAP_EN
            // Only a taken redirect can land on a non-word-aligned target.
            if (Branch_Taken && w_next_pc[1]) begin
              r_pc   <= TRAP_VECTOR;
              r_trap <= 1'b1;
            end else begin
              r_pc <= w_next_pc;
            end
`else
            r_pc <= w_next_pc;
`endif
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifndef INSTR_MISALIGN_TRAP_EN
  logic w_unused_trap_vector;
  assign w_unused_trap_vector = ^TRAP_VECTOR;
`endif

  // Fetch_Valid is decoded from state so an async reset drops it at once.
  assign Fetch_Valid   = (r_state == c_FETCH);
  assign Fetch_Addr    = r_pc;
  assign PC            = r_pc;
  assign PC_Plus_4     = r_pc + DWIDTH'(4);
  assign Trap_Misalign = r_trap;

endmodule
`default_nettype wire

// File: doc/branch_pc_unit.md
# branch_pc_unit

Next-PC and fetch sequencer for the RV32IM core, directly downstream of the branch comparator. Consumes Branch_Equal/Branch_Lt, decodes the B-type condition from funct3, and drives Branch_Un_Ctrl back to the comparator. Selects PC+4, PC+imm or the JALR target, and owns the architectural PC register. Sequences the instruction-fetch handshake so multi-cycle instructions (MUL/DIV) and slow instruction memory stall the PC cleanly.

## Interface
Parameters:
- DWIDTH, 32, datapath/PC width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap (only with INSTR_MISALIGN_TRAP_EN)

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  core clock
- Rst  in  1  asynchronous, active-high reset
- Branch_Equal  in  1  from branch comparator
- Branch_Lt  in  1  from branch comparator
- Branch_Un_Ctrl  out  1  to branch comparator; = Funct3[1]
- Funct3  in  3  instruction funct3
- Branch  in  1  current instruction is B-type
- Jump  in  1  current instruction is JAL or JALR
- Jalr  in  1  current instruction is JALR (qualifies Jump)
- Imm  in  DWIDTH  sign-extended immediate
- Read_Reg_Data_1  in  DWIDTH  rs1 value (JALR base)
- Instr_Retire  in  1  current instruction completes this cycle
- Fetch_Ready  in  1  instruction memory accepts request
- Fetch_Valid  out  1  fetch request
- Fetch_Addr  out  DWIDTH  fetch address (= PC)
- PC  out  DWIDTH  architectural PC
- PC_Plus_4  out  DWIDTH  PC+4, for JAL/JALR link writeback
- Branch_Taken  out  1  combinational redirect decision
- Trap_Misalign  out  1  one-cycle pulse on misaligned target

## Operation
- Condition (Branch=1): 000 BEQ=Eq; 001 BNE=!Eq; 100 BLT=Lt; 101 BGE=!Lt; 110 BLTU=Lt; 111 BGEU=!Lt; 010/011 never taken.
- Branch_Taken = Jump | (Branch & cond).
- Next_PC: Jump&Jalr -> (Read_Reg_Data_1+Imm) & ~1; else Branch_Taken -> PC+Imm; else PC+4. All sums modulo 2^DWIDTH (wrap, no carry out).
- FSM states: IDLE, FETCH, EXEC.
  - IDLE: Fetch_Valid=0; -> FETCH next cycle unconditionally.
  - FETCH: Fetch_Valid=1, Fetch_Addr=PC; Fetch_Valid&Fetch_Ready -> EXEC; else hold with Fetch_Addr stable.
  - EXEC: Fetch_Valid=0; Instr_Retire=1 -> PC<=Next_PC, -> FETCH; else hold PC.
- Instr_Retire outside EXEC is ignored. Branch/Jump/Funct3 sampled only in EXEC at the retire edge.

## Timing
- Reset values: state=IDLE, PC=RESET_VECTOR, Fetch_Valid=0, Trap_Misalign=0; Fetch_Addr=RESET_VECTOR, PC_Plus_4=RESET_VECTOR+4.
- Rst asserted mid-handshake or mid-instruction: all state clears immediately (asynchronous); Fetch_Valid drops in the same cycle.
- First Fetch_Valid: second rising edge after Rst deasserts (IDLE one cycle).
- Minimum instruction period: 2 cycles (FETCH accepted, EXEC with retire).
- PC updates on the edge where EXEC & Instr_Retire; new Fetch_Addr is visible in the following cycle.
- Branch_Taken, Branch_Un_Ctrl, PC_Plus_4: combinational, zero latency.

## Configuration
- INSTR_MISALIGN_TRAP_EN defined: at retire with Branch_Taken=1 and Next_PC[1]=1, PC<=TRAP_VECTOR and Trap_Misalign pulses high for exactly the next cycle. Non-taken branches never trap.
- Not defined: Next_PC is used as computed (bit 1 kept; bit 0 cleared for JALR only); Trap_Misalign tied 0; TRAP_VECTOR unused.

## Test plan
- Reset release, Fetch_Ready=1 -> Fetch_Valid first high 2 cycles after release with Fetch_Addr=0x0; Instr_Retire in EXEC -> Fetch_Addr=0x4.
- Branch=1, Funct3=101 (BGE), Branch_Lt=0, PC=0x100, Imm=0xFFFF_FFF0 -> Branch_Taken=1, next Fetch_Addr=0xF0; same with Funct3=110 -> Branch_Un_Ctrl=1.
- Jump=1, Jalr=1, Read_Reg_Data_1=0x2001, Imm=0x4 -> next PC=0x2004; PC_Plus_4 equals old PC+4 during EXEC.
- Fetch_Ready low 3 cycles, then Instr_Retire held low 4 cycles -> Fetch_Addr stable throughout, PC unchanged until retire.
- PC=0xFFFF_FFFC, non-branch retire -> PC wraps to 0x0; Rst pulsed mid-FETCH -> Fetch_Valid drops immediately, PC=RESET_VECTOR.
- With INSTR_MISALIGN_TRAP_EN: JAL to PC+0x6 -> PC=TRAP_VECTOR, Trap_Misalign high exactly one cycle; without the macro -> PC=target, no pulse.
